digit_split_seq: RTL and testbench

//  Parametrised successor to the byte-to-nibble splitter for the 7-seg UART display path.

---
 rtl/digit_split_seq_pkg.sv | 22 ++
 rtl/digit_split_seq_if.sv | 26 ++
 rtl/digit_split_seq_dd_adjust.sv | 8 +
 rtl/digit_split_seq.sv | 127 ++++++++++++
 tb/tb_digit_split_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/digit_split_seq_pkg.sv
// Shared types and helpers for the digit splitter: FSM states, mode encodings
// and the width helper used to size the double-dabble iteration counter.
package digit_split_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Smallest w with 2**w >= value; a counter of this width reaches value-1.
    function automatic int clog2(input int value);
        for (int w = 0; w < 32; w++) begin
            if ((1 << w) >= value) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/digit_split_seq_if.sv
// Producer/consumer bundle between the UART byte assembler, the splitter and the 7-seg mux.
// Handshake: a value transfers on a rising clk edge where in_valid && in_ready; the producer
// holds in_data/in_mode stable while in_valid is high; out_valid is an unacknowledged 1-cycle pulse.
interface digit_split_seq_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_mode;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   digits;
    logic                  out_valid;
    logic                  overflow;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_mode,
        input  in_ready, digits, out_valid, overflow, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode,
        output in_ready, digits, out_valid, overflow, busy
    );
endinterface

// File: rtl/digit_split_seq_dd_adjust.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module dd_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
endmodule

// File: rtl/digit_split_seq.sv
// Converts a DATA_W-bit value into DIGITS display digits, either as hex nibbles or
// as decimal via a bit-serial double-dabble; results are presented with a 1-cycle pulse.
module digit_split_seq
    import digit_split_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int DIGITS         = 3,
    parameter bit ONLY_ON_CHANGE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    digit_split_seq_if.slave  bus,
    output state_t            state_dbg
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(DATA_W);
    localparam int EXT_W = DATA_W + BCD_W;

    state_t              state, state_next;
    logic [DATA_W-1:0]   cap_data;
    logic                cap_mode;
    logic [DATA_W-1:0]   data_sr;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                bcd_carry;
    logic [CNT_W-1:0]    iter;
    logic                last_valid;
    logic [DATA_W-1:0]   last_data;
    logic                last_mode;
    logic [BCD_W-1:0]    digits_q;
    logic                out_valid_q;
    logic                overflow_q;
    logic                accept;
    logic                unchanged;
    logic                last_iter;
    logic [EXT_W-1:0]    hex_ext;

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.busy      = (state != IDLE);
    assign bus.digits    = digits_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;
    assign state_dbg     = state;

    assign accept    = bus.in_valid && bus.in_ready;
    assign unchanged = ONLY_ON_CHANGE && last_valid &&
                       (bus.in_data == last_data) && (bus.in_mode == last_mode);
    assign last_iter = (iter == CNT_W'(DATA_W - 1));
    assign hex_ext   = EXT_W'(cap_data);

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        dd_adjust u_adj (
            .digit_in  (bcd[4*k +: 4]),
            .digit_out (bcd_adj[4*k +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !unchanged)
                    state_next = (bus.in_mode == MODE_DEC) ? SHIFT : DONE;
            end
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_data    <= '0;
            cap_mode    <= MODE_HEX;
            data_sr     <= '0;
            bcd         <= '0;
            bcd_carry   <= 1'b0;
            iter        <= '0;
            last_valid  <= 1'b0;
            last_data   <= '0;
            last_mode   <= MODE_HEX;
            digits_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !unchanged) begin
                        cap_data  <= bus.in_data;
                        cap_mode  <= bus.in_mode;
                        data_sr   <= bus.in_data;
                        bcd       <= '0;
                        bcd_carry <= 1'b0;
                        iter      <= '0;
                    end
                end
                SHIFT: begin
                    // Whatever leaves the top digit is a decimal digit we cannot show.
                    bcd       <= {bcd_adj[BCD_W-2:0], data_sr[DATA_W-1]};
                    data_sr   <= {data_sr[DATA_W-2:0], 1'b0};
                    bcd_carry <= bcd_carry | bcd_adj[BCD_W-1];
                    iter      <= iter + CNT_W'(1);
                end
                DONE: begin
                    out_valid_q <= 1'b1;
                    last_valid  <= 1'b1;
                    last_data   <= cap_data;
                    last_mode   <= cap_mode;
                    if (cap_mode == MODE_DEC) begin
                        digits_q   <= bcd;
                        overflow_q <= bcd_carry;
                    end else begin
                        digits_q   <= hex_ext[BCD_W-1:0];
                        overflow_q <= |hex_ext[EXT_W-1:BCD_W];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_split_seq.sv
// Directed plus randomized bench for digit_split_seq: a 3-digit change-filtering instance
// and a 2-digit always-convert instance, checked against an arithmetic digit model.
module tb_digit_split_seq;
    import digit_split_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    digit_split_seq_if #(.DATA_W(8), .DIGITS(3)) if3 ();
    digit_split_seq_if #(.DATA_W(8), .DIGITS(2)) if2 ();
    state_t st3, st2;

    digit_split_seq #(.DATA_W(8), .DIGITS(3), .ONLY_ON_CHANGE(1'b1)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if3.slave),
        .state_dbg (st3)
    );

    digit_split_seq #(.DATA_W(8), .DIGITS(2), .ONLY_ON_CHANGE(1'b0)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if2.slave),
        .state_dbg (st2)
    );

    // ---------------- scoreboard state ----------------
    int checks    = 0;
    int failures  = 0;
    int accepts3  = 0;
    logic [12:0] exp_q[$];
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_v     = '0;
    logic        mem_m     = 1'b0;

    // Digits by repeated division; bit 16 flags a value too large for nd digits.
    function automatic logic [31:0] model(input int v, input logic m, input int nd);
        int base;
        int p;
        logic [31:0] r;
        base = m ? 10 : 16;
        p    = 1;
        r    = '0;
        for (int k = 0; k < nd; k++) begin
            r = r | (32'((v / p) % base) << (4 * k));
            p = p * base;
        end
        if (v >= p) r[16] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every dut3 result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (if3.out_valid) begin
            logic [12:0] e;
            check("dut3_pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dut3_result", {19'd0, if3.overflow, if3.digits}, {19'd0, e});
            end
        end
    end

    always @(posedge clk) begin
        if (if3.in_valid && if3.in_ready) accepts3++;
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic do_conv3(input logic [7:0] v, input logic m, input bit keep);
        bit          conv;
        logic [31:0] r;
        logic [11:0] prev;
        int          lat;
        int          rlow;
        conv = !(mem_valid && (v == mem_v) && (m == mem_m));
        r    = model(int'(v), m, 3);
        prev = if3.digits;
        if3.in_valid = 1'b1;
        if3.in_data  = v;
        if3.in_mode  = m;
        for (int w = 0; w < 50 && !if3.in_ready; w++) begin
            @(posedge clk); @(negedge clk);
        end
        check("dut3_ready_for_accept", 32'(if3.in_ready), 32'd1);
        if (conv) exp_q.push_back({r[16], r[11:0]});
        @(posedge clk); @(negedge clk);
        if (!keep) if3.in_valid = 1'b0;
        rlow = int'(!if3.in_ready);
        lat  = 0;
        if (conv) begin
            while (lat < 40 && !if3.out_valid) begin
                @(posedge clk); @(negedge clk);
                lat++;
                rlow += int'(!if3.in_ready);
            end
            check("dut3_latency", 32'(lat), m ? 32'd9 : 32'd1);
            check("dut3_ready_low_cycles", 32'(rlow), m ? 32'd9 : 32'd1);
            mem_valid = 1'b1;
            mem_v     = v;
            mem_m     = m;
            if (!keep) begin
                @(posedge clk); @(negedge clk);
                check("dut3_pulse_width", 32'(if3.out_valid), 32'd0);
            end
        end else begin
            check("dut3_skip_ready", 32'(rlow), 32'd0);
            repeat (12) begin @(posedge clk); @(negedge clk); end
            check("dut3_skip_hold", 32'(if3.digits), 32'(prev));
        end
    endtask

    task automatic do_conv2(input logic [7:0] v, input logic m);
        logic [31:0] r;
        int          lat;
        r = model(int'(v), m, 2);
        if2.in_valid = 1'b1;
        if2.in_data  = v;
        if2.in_mode  = m;
        for (int w = 0; w < 50 && !if2.in_ready; w++) begin
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk); @(negedge clk);
        if2.in_valid = 1'b0;
        lat = 0;
        while (lat < 40 && !if2.out_valid) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check("dut2_latency", 32'(lat), m ? 32'd9 : 32'd1);
        check("dut2_result", {23'd0, if2.overflow, if2.digits}, {23'd0, r[16], r[7:0]});
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          acc0;
        logic [7:0]  rv;
        logic        rm;
        reset        = 1'b1;
        if3.in_valid = 1'b0; if3.in_data = '0; if3.in_mode = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.in_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_digits",    32'(if3.digits),    32'd0);
        check("reset_out_valid", 32'(if3.out_valid), 32'd0);
        check("reset_overflow",  32'(if3.overflow),  32'd0);
        check("reset_busy",      32'(if3.busy),      32'd0);
        check("reset_ready_low", 32'(if3.in_ready),  32'd0);
        check("reset_state",     32'(st3),           32'(IDLE));
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(if3.in_ready), 32'd1);

        do_conv3(8'hA7, MODE_HEX, 1'b0);
        do_conv3(8'd255, MODE_DEC, 1'b0);
        do_conv3(8'd255, MODE_DEC, 1'b0);
        do_conv3(8'd255, MODE_HEX, 1'b0);

        do_conv2(8'd200, MODE_DEC);
        do_conv2(8'd99,  MODE_DEC);
        do_conv2(8'd99,  MODE_DEC);
        do_conv2(8'hFF,  MODE_HEX);

        // Abort a decimal conversion in its 4th shift cycle.
        if3.in_valid = 1'b1; if3.in_data = 8'd255; if3.in_mode = MODE_DEC;
        @(posedge clk); @(negedge clk);
        if3.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("abort_in_shift", 32'(st3), 32'(SHIFT));
        reset = 1'b1;
        #1;
        check("abort_ready_low", 32'(if3.in_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready",    32'(if3.in_ready), 32'd1);
        check("abort_digits",   32'(if3.digits),   32'd0);
        check("abort_overflow", 32'(if3.overflow), 32'd0);
        check("abort_busy",     32'(if3.busy),     32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        repeat (12) begin @(posedge clk); @(negedge clk); end
        do_conv3(8'd255, MODE_DEC, 1'b0);
        do_conv3(8'd255, MODE_DEC, 1'b0);

        // Back-to-back values with in_valid never dropping.
        acc0 = accepts3;
        do_conv3(8'd1, MODE_DEC, 1'b1);
        do_conv3(8'd2, MODE_DEC, 1'b1);
        do_conv3(8'd3, MODE_DEC, 1'b0);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        check("held_valid_accepts", 32'(accepts3 - acc0), 32'd3);

        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 3) begin
                rv = mem_v;
                rm = (i % 8 == 7) ? ~mem_m : mem_m;
            end else begin
                rv = 8'($urandom_range(0, 255));
                rm = 1'($urandom_range(0, 1));
            end
            do_conv3(rv, rm, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            do_conv2(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
